// File: rtl/uart_msg_pkg.sv
// Shared definitions for the UART message streamer: FSM encoding and
// message geometry constants.
package uart_msg_pkg;

  // Bytes unpacked from each 32-bit RAM word.
  localparam int BYTES_PER_WORD = 4;

  // Largest message for the default 128-word RAM.
  localparam int MAX_MSG_BYTES  = 512;

  // FSM state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/uart_msg_streamer_unpacker.sv
// word_byte_unpacker: holds one RAM word and walks through its bytes,
// byte 0 (bits 7:0) first.
module word_byte_unpacker
  import uart_msg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        advance,
  output logic [7:0]  cur_byte,
  output logic        last_in_word
);

  logic [31:0] word_reg;
  logic [1:0]  byte_idx;

  // Capture a new word (index back to byte 0) or step to the next byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg <= '0;
      byte_idx <= '0;
    end else if (load) begin
      word_reg <= load_data;
      byte_idx <= '0;
    end else if (advance) begin
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // Select the current byte and flag the final byte of the word.
  always_comb begin
    cur_byte     = word_reg[{byte_idx, 3'b000} +: 8];
    last_in_word = (byte_idx == 2'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/uart_msg_streamer.sv
// uart_msg_streamer: fetches a byte-length message from a 1-cycle-latency
// word RAM and streams it LSB-first to a UART transmitter.
// Optional build macro: UART_MSG_NUL_TERM_EN (a 0x00 byte ends the message).
//
// tx stream handshake: tx_valid is raised only in SEND and, once raised,
// tx_data stays stable until the cycle a rising edge sees tx_valid && tx_ready;
// that edge is the single transfer of the byte.
module uart_msg_streamer
  import uart_msg_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len_bytes,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [31:0]           rdata,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  // Longest message the RAM can hold (MAX_MSG_BYTES for 7 address bits).
  localparam int MaxLen = BYTES_PER_WORD * (1 << ADDR_WIDTH);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] word_ptr;
  logic [LEN_WIDTH-1:0]  rem_cnt;
  logic [LEN_WIDTH-1:0]  len_clamped;
  logic [7:0]            cur_byte;
  logic                  last_in_word;
  logic                  nul_byte;
  logic                  accept;

  word_byte_unpacker u_unpacker (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (state == ST_LOAD),
    .load_data    (rdata),
    .advance      (accept),
    .cur_byte     (cur_byte),
    .last_in_word (last_in_word)
  );

  // Outputs are decoded from state so an asynchronous reset drops them at once.
  always_comb begin
    read_en   = (state == ST_FETCH);
    raddr     = word_ptr;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    tx_data   = cur_byte;
    state_dbg = state;
`ifdef UART_MSG_NUL_TERM_EN
    nul_byte  = (state == ST_SEND) && (cur_byte == 8'h00);
`else
    nul_byte  = 1'b0;
`endif
    tx_valid  = (state == ST_SEND) && !nul_byte;
    accept    = tx_valid && tx_ready;
    len_clamped = (len_bytes > LEN_WIDTH'(MaxLen)) ? LEN_WIDTH'(MaxLen) : len_bytes;
  end

  // Message sequencer: word pointer, remaining byte count and state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      word_ptr <= '0;
      rem_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            word_ptr <= base_addr;
            rem_cnt  <= len_clamped;
            state    <= (len_bytes == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD:  state <= ST_SEND;
        ST_SEND: begin
          if (nul_byte) begin
            state <= ST_DONE;
          end else if (accept) begin
            rem_cnt <= rem_cnt - 1'b1;
            if (rem_cnt == LEN_WIDTH'(1)) begin
              state <= ST_DONE;
            end else if (last_in_word) begin
              word_ptr <= word_ptr + 1'b1;
              state    <= ST_FETCH;
            end
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_streamer.sv
// Directed bench for uart_msg_streamer with a behavioural 128x32 RAM.
module tb_uart_msg_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  base_addr = '0;
  logic [9:0]  len_bytes = '0;
  logic        read_en;
  logic [6:0]  raddr;
  logic [31:0] rdata = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [2:0]  state_dbg;

  logic [31:0] mem [128];
  logic [7:0]  byte_q[$];
  logic [7:0]  exp_q[$];
  logic [6:0]  addr_q[$];
  logic [6:0]  exp_addr_q[$];
  int          done_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  uart_msg_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len_bytes (len_bytes),
    .read_en   (read_en),
    .raddr     (raddr),
    .rdata     (rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // RAM model: one-cycle read latency
  always @(posedge clk) begin
    if (read_en) rdata <= mem[raddr];
  end

  // Monitor: record transfers, reads and done pulses between edges
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) byte_q.push_back(tx_data);
      if (read_en) addr_q.push_back(raddr);
      if (done) done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    byte_q.delete();
    exp_q.delete();
    addr_q.delete();
    exp_addr_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_msg(input int base, input int len);
    @(posedge clk); #1;
    base_addr = 7'(base);
    len_bytes = 10'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (n < budget && !done) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    @(negedge clk);
    check({tag, "_idle_after"}, busy, 1'b0);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_nbytes"}, byte_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), byte_q[i], exp_q[i]);
    check({tag, "_nreads"}, addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_addr_q.size() && i < addr_q.size(); i++)
      check($sformatf("%s_raddr%0d", tag, i), addr_q[i], exp_addr_q[i]);
    check({tag, "_ndone"}, done_cnt, 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 128; i++) mem[i] = 32'h01010101 * (i + 1);

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_read_en", read_en, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_raddr", raddr, 7'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic send with first-byte timing
    mem[0] = 32'h44434241;
    mem[1] = 32'h00004645;
    clear_obs();
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    exp_addr_q = '{7'd0, 7'd1};
    start_msg(0, 6);
    @(negedge clk);
    check("basic_fetch_read_en", read_en, 1'b1);
    check("basic_fetch_raddr", raddr, 7'd0);
    check("basic_fetch_tx_valid", tx_valid, 1'b0);
    @(negedge clk);
    check("basic_load_read_en", read_en, 1'b0);
    check("basic_load_tx_valid", tx_valid, 1'b0);
    @(negedge clk);
    check("basic_send_tx_valid", tx_valid, 1'b1);
    check("basic_send_tx_data", tx_data, 8'h41);
    wait_done("basic", 50);
    compare_stream("basic");

    // Backpressure on byte 2
    clear_obs();
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    exp_addr_q = '{7'd0, 7'd1};
    start_msg(0, 6);
    n = 0;
    while (n < 20 && !(tx_valid && tx_data == 8'h42)) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_byte1", tx_data, 8'h42);
    @(posedge clk); #1 tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), tx_valid, 1'b1);
      check($sformatf("bp_hold_data%0d", i), tx_data, 8'h43);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_done("bp", 50);
    compare_stream("bp");

    // Address wrap 127 -> 0
    mem[127] = 32'h11223344;
    mem[0]   = 32'h55667788;
    clear_obs();
    exp_q = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    exp_addr_q = '{7'd127, 7'd0};
    start_msg(127, 8);
    wait_done("wrap", 50);
    compare_stream("wrap");

    // Zero length: done the cycle after start, no read, no byte
    clear_obs();
    start_msg(3, 0);
    @(negedge clk);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b1);
    check("zero_read_en", read_en, 1'b0);
    check("zero_tx_valid", tx_valid, 1'b0);
    @(negedge clk);
    check("zero_done_drop", done, 1'b0);
    check("zero_idle", busy, 1'b0);
    check("zero_nreads", addr_q.size(), 0);
    check("zero_nbytes", byte_q.size(), 0);

    // Start while busy is ignored
    mem[0] = 32'h44434241;
    clear_obs();
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    exp_addr_q = '{7'd0, 7'd1};
    start_msg(0, 6);
    repeat (3) @(posedge clk);
    #1;
    base_addr = 7'd9;
    len_bytes = 10'd0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("ign", 50);
    repeat (4) @(negedge clk);
    compare_stream("ign");

    // Length clamp: 600 bytes requested, 512 sent over all 128 words
    clear_obs();
    start_msg(0, 600);
    wait_done("clamp", 1200);
    check("clamp_nbytes", byte_q.size(), 512);
    check("clamp_nreads", addr_q.size(), 128);
    check("clamp_last_raddr", addr_q.size() > 0 ? addr_q[$] : 7'd0, 7'd127);
    check("clamp_ndone", done_cnt, 1);

    // Asynchronous reset mid-SEND
    tx_ready = 1'b0;
    clear_obs();
    start_msg(0, 6);
    n = 0;
    while (n < 10 && !tx_valid) begin
      @(negedge clk);
      n++;
    end
    check("arst_in_send", tx_valid, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("arst_tx_valid", tx_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    tx_ready = 1'b1;
    clear_obs();
    exp_q = '{8'h41};
    exp_addr_q = '{7'd0};
    start_msg(0, 1);
    wait_done("arst", 50);
    compare_stream("arst");

    // NUL byte handling
    mem[0] = 32'h00434241;
    mem[1] = 32'h04030201;
    clear_obs();
`ifdef UART_MSG_NUL_TERM_EN
    exp_q = '{8'h41, 8'h42, 8'h43};
    exp_addr_q = '{7'd0};
`else
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    exp_addr_q = '{7'd0, 7'd1};
`endif
    start_msg(0, 8);
    wait_done("nul", 50);
    compare_stream("nul");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_msg_streamer.md
Name: uart_msg_streamer

Overview:
- Sits directly downstream of the 128x32 block RAM in the UART path.
- On a start pulse, fetches a message from RAM over the RAM's one-cycle-latency read port and unpacks each 32-bit word into bytes, LSB first.
- Presents the bytes to the UART transmitter on a valid/ready byte stream.
- Reports busy and a one-cycle done pulse.

Parameters:
- ADDR_WIDTH, 7, RAM word-address width; address arithmetic wraps modulo 2^ADDR_WIDTH.
- LEN_WIDTH, 10, width of the byte-length input; maximum accepted length is 4*2^ADDR_WIDTH bytes (512).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to send; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address; latched at start.
- len_bytes  in  LEN_WIDTH  message length in bytes; latched at start.
- read_en  out  1  RAM read strobe.
- raddr  out  ADDR_WIDTH  RAM read address.
- rdata  in  32  RAM read data; valid the cycle after read_en is sampled.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready at a rising edge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at message completion.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; tx_valid=0, read_en=0, done=0, busy=0.
  - tx_data=0, raddr=0; all counters 0.
  - Reset mid-message abandons the message; tx_valid drops without waiting for a clock.
- States: IDLE, FETCH, LOAD, SEND, DONE.
- IDLE:
  - start=1 at edge E0 latches base_addr into word pointer and len_bytes into remaining count.
  - A length above 512 is clamped to 512.
  - len_bytes=0 goes to DONE; otherwise goes to FETCH.
- FETCH:
  - read_en=1, raddr=word pointer (combinational from state).
  - Always goes to LOAD next edge.
- LOAD:
  - rdata is valid; at the edge it is latched into a 32-bit word register.
  - Byte index reset to 0; goes to SEND.
- SEND:
  - tx_valid=1; tx_data = word register byte[byte index], byte 0 = bits 7:0.
  - tx_data is held stable while tx_valid && !tx_ready.
  - On accept: remaining count decrements and byte index increments.
  - If the accepted byte was the last of the message, go to DONE.
  - Else, if byte index was 3, increment word pointer (wrapping 127->0) and go to FETCH.
  - Else stay in SEND.
- DONE: done=1 for exactly one cycle, then IDLE. busy is high in DONE.
- Timing:
  - First byte: read_en high for the cycle after E0; tx_valid high from after E0+2 edges.
  - Inter-word bubble: 2 cycles of tx_valid=0 (FETCH, LOAD).
  - Zero-length message: done pulses the cycle after E0, with no RAM read.
  - Partial last word: only the low (len mod 4) bytes are sent; upper bytes are discarded.
- start while busy is ignored and not queued. start held high continuously re-triggers one cycle after DONE, from IDLE.
- read_en is never asserted outside FETCH.

Optional Feature:
- Macro: UART_MSG_NUL_TERM_EN.
- Defined:
  - In SEND, a byte equal to 0x00 ends the message: it is not presented (tx_valid stays 0), and the FSM goes to DONE next edge regardless of the remaining count.
  - len_bytes still caps the message.
- Undefined: 0x00 bytes are transmitted like any other byte; only len_bytes terminates the message.

Decomposition:
- Shared package uart_msg_pkg holds:
  - state enum (IDLE, FETCH, LOAD, SEND, DONE);
  - BYTES_PER_WORD=4;
  - MAX_MSG_BYTES=512.
- One natural sub-module, word_byte_unpacker:
  - holds the 32-bit word register and the 2-bit byte index;
  - provides load, advance, current byte and last-byte-of-word outputs.
- The FSM, pointer and length counters stay in the top.

Test Plan:
- Basic send: RAM[0]=0x44434241, RAM[1]=0x00004645, base=0, len=6, tx_ready=1.
  - Expected bytes 0x41,0x42,0x43,0x44,0x45,0x46.
  - read_en pulses exactly twice, raddr 0 then 1.
  - done pulses once; busy low after.
- Backpressure: same message, tx_ready low 5 cycles on byte 2.
  - tx_data holds 0x43 with tx_valid=1 throughout.
  - No byte is lost or duplicated.
- Wrap: base=127, len=8, RAM[127]=0x11223344, RAM[0]=0x55667788.
  - Expected raddr 127 then 0; bytes 0x44,0x33,0x22,0x11,0x88,0x77,0x66,0x55.
- Zero length and ignored start:
  - len=0 gives done one cycle after start, with no read_en and no tx_valid.
  - start pulsed mid-message does not alter the byte sequence or the done count.
- Async reset mid-SEND: deassert rst_n while tx_valid=1.
  - tx_valid and busy go low before the next clk edge.
  - After release, a new start with len=1 sends exactly one byte.
- Under UART_MSG_NUL_TERM_EN: RAM[0]=0x00434241, len=8.
  - Expected bytes 0x41,0x42,0x43, then done.
  - Without the macro, 8 bytes are sent, including 0x00.
